// File: rtl/trans_assembler.sv
// Byte-to-128-bit transaction assembler with a small output FIFO and valid/ack head register.
// Optional idle timeout on partial frames: define TRANS_ASM_TIMEOUT_EN.
module trans_assembler #(
   parameter int FIFO_DEPTH      = 4,
   parameter int BYTES_PER_TRANS = 16,
   parameter int TIMEOUT_CYCLES  = 1024
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    byte_i,
   input  logic                          byte_valid_i,
   input  logic                          byte_sof_i,
   output logic                          byte_ready_o,
   output logic [127:0]                  data_o,
   output logic                          valid_o,
   input  logic                          ack_i,
   output logic                          frame_err_o,
   output logic [15:0]                   trans_count_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [3:0] LAST_IDX = 4'(BYTES_PER_TRANS - 1);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || BYTES_PER_TRANS != 16 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
      $error("trans_assembler: unsupported parameter set");
   end

   typedef enum logic {
      IDLE,
      COLLECT
   } state_t;

   state_t         state;
   logic [3:0]     byte_cnt;
   logic [119:0]   shift_reg;
   logic [127:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;

   logic           full;
   logic           accept;
   logic           push;
   logic           pop;
   logic [LW-1:0]  remain;
   logic [AW-1:0]  head_idx;

   assign full         = (fifo_level_o == LW'(FIFO_DEPTH));
   assign byte_ready_o = !rst && !(full && byte_cnt == LAST_IDX);
   assign accept       = byte_valid_i && byte_ready_o;
   assign push         = accept && state == COLLECT && !byte_sof_i && byte_cnt == LAST_IDX;
   assign pop          = ack_i && valid_o;

   // The head register sees only words stored before this edge; a word pushed now
   // becomes visible one cycle later, even if the FIFO was just emptied by a pop.
   assign remain   = fifo_level_o - LW'(pop);
   assign head_idx = rd_ptr + AW'(pop);

`ifdef TRANS_ASM_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] idle_cnt;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         byte_cnt      <= '0;
         shift_reg     <= '0;
         frame_err_o   <= 1'b0;
         trans_count_o <= '0;
`ifdef TRANS_ASM_TIMEOUT_EN
         idle_cnt      <= '0;
`endif
      end else begin
         frame_err_o <= 1'b0;
`ifdef TRANS_ASM_TIMEOUT_EN
         if (accept || state == IDLE) idle_cnt <= '0;
`endif
         if (accept) begin
            if (byte_sof_i) begin
               if (state == COLLECT) frame_err_o <= 1'b1;
               shift_reg <= {112'd0, byte_i};
               byte_cnt  <= 4'd1;
               state     <= COLLECT;
            end else if (state == IDLE) begin
               frame_err_o <= 1'b1;
            end else if (byte_cnt == LAST_IDX) begin
               trans_count_o <= trans_count_o + 16'd1;
               byte_cnt      <= '0;
               state         <= IDLE;
            end else begin
               shift_reg <= {shift_reg[111:0], byte_i};
               byte_cnt  <= byte_cnt + 4'd1;
            end
         end
`ifdef TRANS_ASM_TIMEOUT_EN
         else if (state == COLLECT) begin
            if (idle_cnt == TO_LAST) begin
               frame_err_o <= 1'b1;
               byte_cnt    <= '0;
               state       <= IDLE;
               idle_cnt    <= '0;
            end else begin
               idle_cnt <= idle_cnt + 16'd1;
            end
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {shift_reg, byte_i};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_level_o <= '0;
         valid_o      <= 1'b0;
         data_o       <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         fifo_level_o <= fifo_level_o + LW'(push) - LW'(pop);
         valid_o      <= (remain != '0);
         data_o       <= (remain != '0) ? mem[head_idx] : '0;
      end
   end

endmodule

// File: doc/trans_assembler.md
Name: trans_assembler

Overview:
Upstream neighbour of the transaction validator. Collects a byte stream into 128-bit transaction words, first byte into [127:120]. Buffers completed words in a small FIFO and presents them on a valid/ack handshake that matches the validator: valid held until the validator acks. Discards malformed partial frames and reports framing errors.

Parameters:
FIFO_DEPTH, 4, number of completed 128-bit words buffered (power of 2, >=2)
BYTES_PER_TRANS, 16, bytes per transaction word (fixed at 16; not for override)
TIMEOUT_CYCLES, 1024, idle cycles before a partial frame is dropped (used only with the optional feature)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
byte_i  input  8  incoming byte
byte_valid_i  input  1  byte_i valid this cycle
byte_sof_i  input  1  byte_i is the first byte of a transaction; qualified by byte_valid_i
byte_ready_o  output  1  byte accepted when byte_valid_i && byte_ready_o
data_o  output  128  head-of-FIFO transaction word; [127:80] sender, [79:32] receiver, [31:10] amount, [9] block start
valid_o  output  1  data_o valid; held until ack_i
ack_i  input  1  single-cycle pulse from consumer; pops head word
frame_err_o  output  1  one-cycle pulse on a dropped partial frame
trans_count_o  output  16  words pushed since reset, wraps at 65535->0
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  words currently stored

Behaviour:
- Reset (async, immediate): byte_cnt=0, state=IDLE, FIFO empty. valid_o=0, data_o=0, frame_err_o=0, trans_count_o=0, fifo_level_o=0, byte_ready_o=0 while rst high.
- States: IDLE (byte_cnt=0) and COLLECT (1..15 bytes held in a 120-bit shift register).
- IDLE: accepted byte with byte_sof_i=1 -> store, byte_cnt=1, go COLLECT. Accepted byte with byte_sof_i=0 -> discard, pulse frame_err_o, stay IDLE.
- COLLECT: accepted byte with byte_sof_i=0 -> shift in, byte_cnt+1.
- On the 16th byte: push {shift_reg, byte_i} into the FIFO, increment trans_count_o, return to IDLE. The push takes one cycle.
- COLLECT, accepted byte with byte_sof_i=1 -> drop the partial frame, pulse frame_err_o, restart with this byte as byte 1 (byte_cnt=1).
- byte_ready_o = !rst && !(fifo full && byte_cnt==15), registered-free combinational. Bytes 1..15 are always accepted; only the completing byte stalls.
- FIFO output: valid_o = !empty; data_o = head word. Both are registered (head register), so a pushed word appears on valid_o one cycle after the push edge.
- Pop: ack_i && valid_o at a rising edge -> advance head. The next word, if any, is presented on the following cycle with valid_o continuously high. ack_i while valid_o=0 is ignored.
- The consumer acks one cycle after it samples valid_o. valid_o and data_o must stay stable from assertion through the ack cycle inclusive.
- Simultaneous push and pop: level unchanged.
- Push when full: prevented by byte_ready_o.
- Pop of the last word with a simultaneous push: the new word is presented on the next cycle.
- fifo_level_o = pushes minus pops, range 0..FIFO_DEPTH.
- Reset mid-frame or mid-handshake: all state lost, no frame_err_o.

Optional Feature:
Macro TRANS_ASM_TIMEOUT_EN.
- Defined: 16-bit idle counter, cleared on every accepted byte and while IDLE, incremented in COLLECT while no byte is accepted. On reaching TIMEOUT_CYCLES: drop the partial frame, pulse frame_err_o, go IDLE, clear the counter.
- Not defined: no counter; a partial frame waits indefinitely.

Test Plan:
- 16 bytes 0x00..0x0F, sof on the first, ack_i pulsed 1 cycle after valid_o rises -> data_o=128'h000102...0F, valid_o high until ack, then 0; trans_count_o=1, fifo_level_o 1->0.
- 5 back-to-back frames, ack_i held low -> 4 words stored, fifo_level_o=4, byte_ready_o=0 exactly at byte 16 of frame 5. After one ack: frame 5 accepted, FIFO order preserved.
- 7 bytes then a new sof byte 0xAA + 15 bytes -> one frame_err_o pulse; output word starts 0xAA; trans_count_o=1.
- Byte without sof in IDLE (0x55) -> frame_err_o pulse, nothing pushed, fifo_level_o=0.
- Push and ack on the same edge with level 2 -> level stays 2; next data_o is the second-oldest word; valid_o never drops.
- TRANS_ASM_TIMEOUT_EN, TIMEOUT_CYCLES=8: 3 bytes then 8 idle cycles -> frame_err_o on the 8th idle cycle; next sof frame assembles correctly. rst asserted mid-frame -> outputs zero immediately with no frame_err_o.
